wb_port_arbiter: RTL

//  Shares the single register-file write port among three writeback sources:
//   - ALU/link path (R/I/LUI/AUIPC results, JAL/JALR PC+4)
//   - load unit (variable-latency memory read data)
//   - mul/div unit (multi-cycle results)

---
 rtl/riscv_wb_pkg.sv | 22 ++
 rtl/wb_slot.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared constants for the writeback port arbiter.
//   XLEN       result / write-data width
//   REGADDR_W  destination register index width
//   SRC_*      writeback source indices, also the wb_src encoding
package riscv_wb_pkg;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;
  localparam int NUM_SRC   = 3;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_ALU = 2'd0;
  localparam src_idx_t SRC_LD  = 2'd1;
  localparam src_idx_t SRC_MD  = 2'd2;

  // Next source index in round-robin order (0 -> 1 -> 2 -> 0).
  function automatic src_idx_t rr_next(input src_idx_t idx);
    return (idx == SRC_MD) ? SRC_ALU : src_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single writeback source.
//   clk, rst   clock, async active-high reset (discards the entry)
//   i_valid    source offers an entry (i_rd / i_data)
//   i_clear    entry is granted this cycle and leaves the slot
//   o_ready    slot can take an entry this cycle (empty, or emptying now)
//   o_full     slot holds an entry (o_rd / o_data)
module wb_slot
  import riscv_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [REGADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]      i_data,
  input  logic                 i_clear,
  output logic                 o_ready,
  output logic                 o_full,
  output logic [REGADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]      o_data
);

  logic                 r_full;
  logic [REGADDR_W-1:0] r_rd;
  logic [XLEN-1:0]      r_data;

  // Being granted frees the slot at the same edge, so a refill is allowed.
  assign o_ready = ~r_full | i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_rd   <= i_rd;
      r_data <= i_data;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_rd   = r_rd;
  assign o_data = r_data;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among ALU/link, load and mul/div
// writeback sources. Each source feeds a one-entry slot; full slots are
// granted round-robin, one per cycle, onto registered rf_* outputs.
//   clk, rst                     clock, async active-high reset
//   {alu,ld,md}_valid/rd/data    source offers
//   {alu,ld,md}_ready            source slot accepts this cycle
//   rf_we/rf_waddr/rf_wdata      registered write port
//   wb_src                       source index of the last grant
//   busy                         any slot full
module wb_port_arbiter
  import riscv_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REGADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 ld_valid,
  input  logic [REGADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  output logic                 ld_ready,
  input  logic                 md_valid,
  input  logic [REGADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]      md_data,
  output logic                 md_ready,
  output logic                 rf_we,
  output logic [REGADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [1:0]           wb_src,
  output logic                 busy
);

  logic [NUM_SRC-1:0]   w_in_valid;
  logic [REGADDR_W-1:0] w_in_rd   [NUM_SRC];
  logic [XLEN-1:0]      w_in_data [NUM_SRC];
  logic [NUM_SRC-1:0]   w_ready;
  logic [NUM_SRC-1:0]   w_full;
  logic [NUM_SRC-1:0]   w_clear;
  logic [REGADDR_W-1:0] w_slot_rd   [NUM_SRC];
  logic [XLEN-1:0]      w_slot_data [NUM_SRC];

  logic                 w_grant_vld;
  src_idx_t             w_grant_idx;

  src_idx_t             r_ptr;
  logic                 r_we;
  logic [REGADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]      r_wdata;
  src_idx_t             r_src;

  assign w_in_valid   = {md_valid, ld_valid, alu_valid};
  assign w_in_rd[0]   = alu_rd;
  assign w_in_rd[1]   = ld_rd;
  assign w_in_rd[2]   = md_rd;
  assign w_in_data[0] = alu_data;
  assign w_in_data[1] = ld_data;
  assign w_in_data[2] = md_data;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    wb_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_in_valid[g]),
      .i_rd    (w_in_rd[g]),
      .i_data  (w_in_data[g]),
      .i_clear (w_clear[g]),
      .o_ready (w_ready[g]),
      .o_full  (w_full[g]),
      .o_rd    (w_slot_rd[g]),
      .o_data  (w_slot_data[g])
    );
  end

  // Scan the three sources starting just after the pointer; the first
  // full slot wins. The pointer itself is scanned last.
  always_comb begin
    src_idx_t cand;
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    cand        = rr_next(r_ptr);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_grant_vld && w_full[cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    w_clear = '0;
    if (w_grant_vld) w_clear[w_grant_idx] = 1'b1;
  end

  // Pointer resets to MD so ALU is first in line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= SRC_MD;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_src   <= SRC_ALU;
    end else if (w_grant_vld) begin
      // x0 entries are consumed and take their turn, but never write.
      r_we    <= (w_slot_rd[w_grant_idx] != '0);
      r_waddr <= w_slot_rd[w_grant_idx];
      r_wdata <= w_slot_data[w_grant_idx];
      r_src   <= w_grant_idx;
      r_ptr   <= w_grant_idx;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign alu_ready = w_ready[0];
  assign ld_ready  = w_ready[1];
  assign md_ready  = w_ready[2];
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign wb_src    = r_src;
  assign busy      = |w_full;

endmodule
